// File: rtl/monitor_pkg.sv
// Shared types and constants for the Diffie-Hellman exchange monitor.
package monitor_pkg;

  typedef enum logic [2:0] {
    GEN,
    EXP_A,
    EXP_B,
    EXP_SA,
    EXP_SB,
    CHECK
  } state_e;

  localparam logic [15:0] LFSR_TAPS  = 16'hB400;
  localparam int unsigned EXP_CYCLES = 18;
  localparam logic [4:0]  EXP_LAST   = 5'(EXP_CYCLES - 1);

  // Right-shifting Galois LFSR for x^16+x^14+x^13+x^11+1.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

  function automatic logic [15:0] mod_mul(input logic [15:0] x,
                                          input logic [15:0] y,
                                          input logic [15:0] m);
    logic [31:0] prod;
    prod = {16'h0, x} * {16'h0, y};
    return 16'(prod % {16'h0, m});
  endfunction

endpackage

// File: rtl/modexp.sv
// Left-to-right square-and-multiply modular exponentiation, one exponent bit per cycle.
module modexp
  import monitor_pkg::*;
#(
  parameter logic [15:0] P = 16'd65521
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] base,
  input  logic [15:0] exp,
  output logic [15:0] result,
  output logic        done
);

  logic [15:0] r_q, r_d;
  logic [15:0] base_q;
  logic [15:0] exp_q;
  logic [4:0]  bits_q;
  logic        busy_q;
  logic        done_q;
  logic [15:0] r_sq;

  always_comb begin
    r_sq = mod_mul(r_q, r_q, P);
    r_d  = exp_q[15] ? mod_mul(r_sq, base_q, P) : r_sq;
  end

  // NOTE: state registers use non-blocking assignments so every register samples
  // pre-edge values; blocking here would chain updates within one edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q    <= '0;
      base_q <= '0;
      exp_q  <= '0;
      bits_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        r_q    <= 16'd1;
        base_q <= base;
        exp_q  <= exp;
        bits_q <= 5'd16;
        busy_q <= 1'b1;
      end else if (busy_q) begin
        r_q    <= r_d;
        exp_q  <= exp_q << 1;
        bits_q <= bits_q - 5'd1;
        if (bits_q == 5'd1) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign result = r_q;
  assign done   = done_q;

endmodule

// File: rtl/monitor.sv
// Free-running Diffie-Hellman exchange: LFSR private keys, four shared-unit exponentiations, secret compare.
module monitor
  import monitor_pkg::*;
#(
  parameter logic [15:0] P      = 16'd65521,
  parameter logic [15:0] G      = 16'd3,
  parameter logic [15:0] SEED_A = 16'hACE1,
  parameter logic [15:0] SEED_B = 16'h1D2C
) (
  input  logic        clk,
  input  logic        rst,
  output logic        synced,
  output logic [31:0] sync_count,
  output logic [63:0] iter_count
);

  state_e      state_q, state_d;
  logic [4:0]  cyc_q, cyc_d;
  logic [15:0] lfsr_a_q, lfsr_a_d, lfsr_b_q, lfsr_b_d;
  logic [15:0] a_q, a_d, b_q, b_d;
  logic [15:0] pub_a_q, pub_a_d, pub_b_q, pub_b_d;
  logic [15:0] sec_a_q, sec_a_d, sec_b_q, sec_b_d;
  logic        synced_q, synced_d;
  logic [31:0] sync_cnt_q, sync_cnt_d;
  logic [63:0] iter_cnt_q, iter_cnt_d;

  logic        mx_start, mx_done;
  logic [15:0] mx_base, mx_exp, mx_result;

  modexp #(.P(P)) u_modexp (
    .clk    (clk),
    .rst    (rst),
    .start  (mx_start),
    .base   (mx_base),
    .exp    (mx_exp),
    .result (mx_result),
    .done   (mx_done)
  );

  // NOTE: every signal gets a default at the top so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    lfsr_a_d   = lfsr_a_q;
    lfsr_b_d   = lfsr_b_q;
    a_d        = a_q;
    b_d        = b_q;
    pub_a_d    = pub_a_q;
    pub_b_d    = pub_b_q;
    sec_a_d    = sec_a_q;
    sec_b_d    = sec_b_q;
    synced_d   = synced_q;
    sync_cnt_d = sync_cnt_q;
    iter_cnt_d = iter_cnt_q;
    mx_start   = 1'b0;
    mx_base    = G;
    mx_exp     = a_q;

    case (state_q)
      EXP_B:   begin mx_base = G;       mx_exp = b_q; end
      EXP_SA:  begin mx_base = pub_b_q; mx_exp = a_q; end
      EXP_SB:  begin mx_base = pub_a_q; mx_exp = b_q; end
      default: begin mx_base = G;       mx_exp = a_q; end
    endcase

    case (state_q)
      GEN: begin
        a_d      = lfsr_a_q;
        b_d      = lfsr_b_q;
        lfsr_a_d = lfsr_step(lfsr_a_q);
        lfsr_b_d = lfsr_step(lfsr_b_q);
        cyc_d    = '0;
        state_d  = EXP_A;
      end
      EXP_A, EXP_B, EXP_SA, EXP_SB: begin
        mx_start = (cyc_q == 5'd0);
        cyc_d    = cyc_q + 5'd1;
        if (mx_done) begin
          case (state_q)
            EXP_A:   pub_a_d = mx_result;
            EXP_B:   pub_b_d = mx_result;
            EXP_SA:  sec_a_d = mx_result;
            default: sec_b_d = mx_result;
          endcase
        end
        if (cyc_q == EXP_LAST) begin
          cyc_d = '0;
          case (state_q)
            EXP_A:   state_d = EXP_B;
            EXP_B:   state_d = EXP_SA;
            EXP_SA:  state_d = EXP_SB;
            default: state_d = CHECK;
          endcase
        end
      end
      CHECK: begin
        synced_d   = (sec_a_q == sec_b_q);
        iter_cnt_d = iter_cnt_q + 64'd1;
        if (sec_a_q == sec_b_q) sync_cnt_d = sync_cnt_q + 32'd1;
        state_d    = GEN;
      end
      default: state_d = GEN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= GEN;
      cyc_q      <= '0;
      lfsr_a_q   <= SEED_A;
      lfsr_b_q   <= SEED_B;
      a_q        <= '0;
      b_q        <= '0;
      pub_a_q    <= '0;
      pub_b_q    <= '0;
      sec_a_q    <= '0;
      sec_b_q    <= '0;
      synced_q   <= 1'b0;
      sync_cnt_q <= '0;
      iter_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      lfsr_a_q   <= lfsr_a_d;
      lfsr_b_q   <= lfsr_b_d;
      a_q        <= a_d;
      b_q        <= b_d;
      pub_a_q    <= pub_a_d;
      pub_b_q    <= pub_b_d;
      sec_a_q    <= sec_a_d;
      sec_b_q    <= sec_b_d;
      synced_q   <= synced_d;
      sync_cnt_q <= sync_cnt_d;
      iter_cnt_q <= iter_cnt_d;
    end
  end

  assign synced     = synced_q;
  assign sync_count = sync_cnt_q;
  assign iter_count = iter_cnt_q;

endmodule

// File: tb/tb_monitor.sv
// Directed bench for monitor and its modexp unit.
module tb_monitor;

  logic        clk = 1'b0;
  logic        clk_en = 1'b1;
  logic        rst;
  logic        synced;
  logic [31:0] sync_count;
  logic [63:0] iter_count;

  logic        mx_rst, mx_start, mx_done;
  logic [15:0] mx_base, mx_exp, mx_result;

  int checks = 0;
  int errors = 0;

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  monitor dut (
    .clk        (clk),
    .rst        (rst),
    .synced     (synced),
    .sync_count (sync_count),
    .iter_count (iter_count)
  );

  modexp #(.P(16'd65521)) u_mx (
    .clk    (clk),
    .rst    (mx_rst),
    .start  (mx_start),
    .base   (mx_base),
    .exp    (mx_exp),
    .result (mx_result),
    .done   (mx_done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic s, input logic [31:0] sc,
                            input logic [63:0] ic);
    check({tag, "_synced"}, 64'(synced), 64'(s));
    check({tag, "_sync_count"}, 64'(sync_count), 64'(sc));
    check({tag, "_iter_count"}, iter_count, ic);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_mx(input string tag, input logic [15:0] b, input logic [15:0] e,
                        input logic [15:0] expected);
    int n;
    @(negedge clk);
    mx_base  = b;
    mx_exp   = e;
    mx_start = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) mx_start = 1'b0;
    end while (!mx_done && n < 40);
    check({tag, "_done_cycle"}, 64'(n), 64'd17);
    check({tag, "_result"}, 64'(mx_result), 64'(expected));
  endtask

  initial begin
    rst      = 1'b0;
    mx_rst   = 1'b0;
    mx_start = 1'b0;
    mx_base  = '0;
    mx_exp   = '0;

    // Reset held for two cycles.
    tick(2);
    check_outs("reset", 1'b0, 32'd0, 64'd0);

    // First iteration: nothing changes until edge 74.
    @(negedge clk);
    rst    = 1'b1;
    mx_rst = 1'b1;
    for (int i = 1; i <= 73; i++) begin
      tick(1);
      check("first_iter_hold", iter_count, 64'd0);
    end
    tick(1);
    check_outs("first_iter", 1'b1, 32'd1, 64'd1);

    // Reset asserted with the clock stopped takes effect at once and holds.
    @(negedge clk);
    clk_en = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_outs("stopped_clk_rst", 1'b0, 32'd0, 64'd0);
    #200;
    check_outs("stopped_clk_hold", 1'b0, 32'd0, 64'd0);
    clk_en = 1'b1;
    @(negedge clk);
    rst = 1'b1;

    // Steady state: 100 back-to-back exchanges.
    for (int it = 1; it <= 100; it++) begin
      tick(37);
      check("steady_synced_mid", 64'(synced), (it == 1) ? 64'd0 : 64'd1);
      tick(36);
      check("steady_iter_before", iter_count, 64'(it - 1));
      tick(1);
      check_outs("steady", 1'b1, 32'(it), 64'(it));
    end

    // Mid-run reset at cycle 40 of iteration 3.
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_outs("pre_midrun_rst", 1'b0, 32'd0, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    tick(148);
    check("midrun_two_iters", iter_count, 64'd2);
    tick(40);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_outs("midrun_rst", 1'b0, 32'd0, 64'd0);
    tick(2);
    @(negedge clk);
    rst = 1'b1;
    tick(73);
    check("midrun_hold", iter_count, 64'd0);
    tick(1);
    check_outs("midrun_after", 1'b1, 32'd1, 64'd1);

    // Counter wrap: preload all-ones partway through the next iteration.
    repeat (10) @(posedge clk);
    @(negedge clk);
    force dut.iter_cnt_q = '1;
    force dut.sync_cnt_q = '1;
    @(posedge clk);
    @(negedge clk);
    release dut.iter_cnt_q;
    release dut.sync_cnt_q;
    tick(62);
    check("wrap_preload_iter", iter_count, 64'hFFFF_FFFF_FFFF_FFFF);
    tick(1);
    check_outs("wrap", 1'b1, 32'd0, 64'd0);
    tick(74);
    check_outs("post_wrap", 1'b1, 32'd1, 64'd1);

    // modexp unit vectors.
    run_mx("mx_3_pow_4", 16'd3, 16'd4, 16'd81);
    run_mx("mx_2_pow_16", 16'd2, 16'd16, 16'd15);
    run_mx("mx_exp_zero", 16'd12345, 16'd0, 16'd1);
    run_mx("mx_neg1_pow_3", 16'd65520, 16'd3, 16'd65520);
    run_mx("mx_zero_base", 16'd0, 16'd5, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
